// File: rtl/spi_frame_master_pkg.sv
// rtl/spi_frame_master_pkg.sv - shared state encoding and SPI mode constants for the frame master
package spi_frame_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_e;

    // Mode 0: SCK idles low, data launched on fall and captured on rise.
    localparam logic SPI_CPOL = 1'b0;

    localparam int DEFAULT_CLK_DIV      = 4;
    localparam int DEFAULT_FRAME_BYTES  = 64;
    localparam int DEFAULT_SETUP_HALVES = 1;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK half-period tick counter
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - mode-0 SPI master moving one FRAME_BYTES frame per start under one SSEL
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int FRAME_BYTES  = DEFAULT_FRAME_BYTES,
    parameter int SETUP_HALVES = DEFAULT_SETUP_HALVES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

    localparam int            HW    = (SETUP_HALVES > 2) ? $clog2(SETUP_HALVES) : 1;
    localparam logic [HW-1:0] HLAST = HW'(SETUP_HALVES - 1);
    localparam logic [8:0]    NBYTE = 9'(FRAME_BYTES);

    state_e      state_q, state_d;
    logic [6:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ssel_q, ssel_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        tick;
    logic        sck_clear;
    logic        sck_en;

    assign sck_en    = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    assign sck_clear = (state_q == ST_LOAD) && tx_valid && (byte_cnt_q == 9'd0);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (sck_clear),
        .enable (sck_en),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        half_cnt_d = half_cnt_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ssel_d     = ssel_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // busy covers the done cycle so a start coincident with done is dropped
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = ST_LOAD;
                    busy_d     = 1'b1;
                    byte_cnt_d = 9'd0;
                end
            end
            ST_LOAD: begin
                if (tx_valid) begin
                    tx_shift_d = tx_data[6:0];
                    mosi_d     = tx_data[7];
                    bit_cnt_d  = 3'd0;
                    if (byte_cnt_q == 9'd0) begin
                        state_d    = ST_SETUP;
                        ssel_d     = 1'b0;
                        half_cnt_d = '0;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    if (half_cnt_q == HLAST) begin
                        state_d = ST_XFER;
                    end else begin
                        half_cnt_d = half_cnt_q + HW'(1);
                    end
                end
            end
            ST_XFER: begin
                if (tick && !sck_q) begin
                    sck_d      = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], MISO};
                end else if (tick) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q != 3'd7) begin
                        mosi_d     = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        byte_cnt_d = byte_cnt_q + 9'd1;
                        if (byte_cnt_q + 9'd1 == NBYTE) begin
                            state_d    = ST_HOLD;
                            half_cnt_d = '0;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (half_cnt_q == HLAST) begin
                        state_d = ST_IDLE;
                        ssel_d  = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        half_cnt_d = half_cnt_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            half_cnt_q <= '0;
            sck_q      <= SPI_CPOL;
            mosi_q     <= 1'b0;
            ssel_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            half_cnt_q <= half_cnt_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ssel_q     <= ssel_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = (state_q == ST_LOAD);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign SSEL     = ssel_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - randomized frame bench with a mode-0 slave/bus model
module tb_spi_frame_master;

    localparam int C = 4;
    localparam int N = 6;
    localparam int S = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;

    logic       loopback = 1'b0;
    logic       slave_miso = 1'b0;
    logic [7:0] slv_bytes [N];
    logic [7:0] tx_bytes  [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign MISO = loopback ? MOSI : slave_miso;

    spi_frame_master #(
        .CLK_DIV      (C),
        .FRAME_BYTES  (N),
        .SETUP_HALVES (S)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .done     (done),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .SSEL     (SSEL)
    );

    // Bus monitor and mode-0 slave: running totals only, the tasks take differences.
    int n_ssel_fall = 0, n_ssel_rise = 0, n_sck_rise = 0, n_mode_viol = 0;
    int n_width_viol = 0, n_done = 0, n_done_viol = 0, n_rx = 0, ssel_low = 0;
    int cyc = 0, last_edge = 0, rise_in_frame = 0, mbits = 0, s_byte = 0, s_bit = 0;
    logic [7:0] mbyte = 8'h00;
    logic prev_ssel = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [7:0] rx_log [$];
    logic [7:0] mosi_log [$];

    always @(negedge clk) begin
        cyc++;
        if (!SSEL) ssel_low++;
        if (prev_ssel && !SSEL) begin
            n_ssel_fall++;
            rise_in_frame = 0;
            mbits = 0;
            s_byte = 0;
            s_bit = 0;
            slave_miso = slv_bytes[0][7];
        end
        if (!prev_ssel && SSEL) begin
            n_ssel_rise++;
            if (rst_n && (prev_sck || SCK)) n_mode_viol++;
        end
        if (SCK != prev_sck && SSEL && prev_ssel) n_mode_viol++;
        if (MOSI != prev_mosi && SCK && rst_n) n_mode_viol++;
        if (!prev_sck && SCK) begin
            n_sck_rise++;
            if ((rise_in_frame % 8) != 0 && (cyc - last_edge) != C) n_width_viol++;
            rise_in_frame++;
            mbyte = {mbyte[6:0], MOSI};
            mbits++;
            if (mbits == 8) begin
                mosi_log.push_back(mbyte);
                mbits = 0;
            end
            last_edge = cyc;
        end
        if (prev_sck && !SCK) begin
            if (rst_n && (cyc - last_edge) != C) n_width_viol++;
            last_edge = cyc;
            if (!SSEL) begin
                s_bit++;
                if (s_bit == 8) begin
                    s_bit = 0;
                    s_byte++;
                end
                slave_miso = (s_byte < N) ? slv_bytes[s_byte][7 - s_bit] : 1'b0;
            end
        end
        if (rx_valid) begin
            n_rx++;
            rx_log.push_back(rx_data);
        end
        if (done) begin
            n_done++;
            if (!(SSEL && !prev_ssel && busy)) n_done_viol++;
        end
        prev_ssel = SSEL;
        prev_sck  = SCK;
        prev_mosi = MOSI;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int w = 0; w < 600 && !got; w++) begin
            if (tx_ready) got = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        check("tx_accept", int'(got), 1);
    endtask

    task automatic wait_ready();
        bit rdy;
        rdy = 1'b0;
        for (int w = 0; w < 600 && !rdy; w++) begin
            if (tx_ready) rdy = 1'b1;
            else step();
        end
        check("stall_ready", int'(rdy), 1);
    endtask

    // after_mode: 0 idle after done, 1 start on the done cycle, 2 start on the cycle after done
    task automatic run_frame(input bit lb, input bit ramp, input int stall_byte, input int stall_len,
                             input int busy_byte, input int after_mode, input bit do_start);
        int s_fall, s_rise, s_sck, s_mode, s_width, s_done, s_dviol, s_low, s_rx, s_mosi;
        int exp_low;
        bit seen;
        logic [7:0] exp_rx [N];
        loopback = lb;
        for (int i = 0; i < N; i++) begin
            tx_bytes[i]  = ramp ? 8'(i) : 8'($urandom);
            slv_bytes[i] = 8'($urandom);
            exp_rx[i]    = lb ? tx_bytes[i] : slv_bytes[i];
        end
        exp_low = 2 * S * C + 16 * C * N + (N - 1) + ((stall_byte > 0) ? stall_len : 0);
        s_fall = n_ssel_fall;  s_rise = n_ssel_rise;  s_sck = n_sck_rise;
        s_mode = n_mode_viol;  s_width = n_width_viol; s_done = n_done;
        s_dviol = n_done_viol; s_low = ssel_low;       s_rx = rx_log.size();
        s_mosi = mosi_log.size();
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check("busy_after_start", int'(busy), 1);
            check("ready_after_start", int'(tx_ready), 1);
        end
        for (int i = 0; i < N; i++) begin
            if (i == stall_byte) begin
                wait_ready();
                repeat (stall_len) step();
            end
            send_byte(tx_bytes[i]);
            if (i == busy_byte) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        seen = 1'b0;
        for (int w = 0; w < 16 * C + 2 * S * C + 200 && !seen; w++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check("done_seen", int'(seen), 1);
        check("busy_on_done", int'(busy), 1);
        check("rx_count", rx_log.size() - s_rx, N);
        check("mosi_count", mosi_log.size() - s_mosi, N);
        for (int i = 0; i < N; i++) begin
            check("rx_byte", int'(rx_log[s_rx + i]), int'(exp_rx[i]));
            check("mosi_byte", int'(mosi_log[s_mosi + i]), int'(tx_bytes[i]));
        end
        check("rx_hold", int'(rx_data), int'(exp_rx[N-1]));
        check("ssel_falls", n_ssel_fall - s_fall, 1);
        check("ssel_rises", n_ssel_rise - s_rise, 1);
        check("sck_rises", n_sck_rise - s_sck, 8 * N);
        check("mode0_viol", n_mode_viol - s_mode, 0);
        check("sck_width_viol", n_width_viol - s_width, 0);
        check("done_pulses", n_done - s_done, 1);
        check("done_align_viol", n_done_viol - s_dviol, 0);
        check("ssel_low_cycles", ssel_low - s_low, exp_low);
        if (after_mode == 1) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check("busy_after_done", int'(busy), 0);
            repeat (10) step();
            check("ignored_start_fall", n_ssel_fall - s_fall, 1);
            check("ignored_start_busy", int'(busy) + int'(tx_ready), 0);
        end else if (after_mode == 2) begin
            step();
            check("busy_after_done", int'(busy), 0);
            start = 1'b1;
            step();
            start = 1'b0;
            check("restart_busy", int'(busy), 1);
        end else begin
            step();
            check("busy_after_done", int'(busy), 0);
        end
    endtask

    initial begin
        int bad;
        int s_sck, s_rx, s_done;
        for (int i = 0; i < N; i++) slv_bytes[i] = 8'h00;
        repeat (2) step();
        check("rst_ssel", int'(SSEL), 1);
        check("rst_sck", int'(SCK), 0);
        check("rst_mosi", int'(MOSI), 0);
        check("rst_tx_ready", int'(tx_ready), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        bad = 0;
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        repeat (5) begin
            if (tx_ready || busy) bad++;
            step();
        end
        tx_valid = 1'b0;
        check("idle_tx_ready", bad, 0);

        run_frame(1'b0, 1'b0, -1, 0, -1, 0, 1'b1);
        run_frame(1'b1, 1'b1, -1, 0, -1, 0, 1'b1);
        run_frame(1'b0, 1'b0, 2, 20, -1, 0, 1'b1);
        run_frame(1'b0, 1'b0, -1, 0, 1, 1, 1'b1);
        run_frame(1'b1, 1'b0, -1, 0, -1, 2, 1'b1);
        run_frame(1'b0, 1'b0, -1, 0, -1, 0, 1'b0);
        repeat (4) begin
            run_frame(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, N - 1)),
                      int'($urandom_range(0, 30)), -1, 0, 1'b1);
        end

        // Reset in the middle of byte 3, bit 4.
        loopback = 1'b0;
        for (int i = 0; i < N; i++) begin
            tx_bytes[i]  = 8'($urandom);
            slv_bytes[i] = 8'($urandom);
        end
        s_sck = n_sck_rise;
        s_rx = n_rx;
        s_done = n_done;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(tx_bytes[i]);
        for (int w = 0; w < 2000 && (n_sck_rise - s_sck) < 28; w++) step();
        check("reset_point", n_sck_rise - s_sck, 28);
        rst_n = 1'b0;
        #1;
        check("midrst_ssel", int'(SSEL), 1);
        check("midrst_sck", int'(SCK), 0);
        check("midrst_mosi", int'(MOSI), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) step();
        check("midrst_rx_count", n_rx - s_rx, 3);
        check("midrst_done", n_done - s_done, 0);
        check("midrst_idle", int'(SSEL) + int'(busy) + int'(tx_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
